// File: rtl/wash_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wash_pkg
// Purpose : Shared types and codes for the washer phase timer.
// Revision: 1.0 - initial release
// ============================================================================
package wash_pkg;

  // Phase timer states
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_COUNT_CYCLE = 3'd1,
    ST_COUNT_SPIN  = 3'd2,
    ST_WATCH_FILL  = 3'd3,
    ST_WATCH_DRAIN = 3'd4,
    ST_EXPIRED     = 3'd5,
    ST_FAULT       = 3'd6
  } state_e;

  // Wash program codes (code 3 behaves as normal)
  localparam logic [1:0] PROG_QUICK  = 2'd0;
  localparam logic [1:0] PROG_NORMAL = 2'd1;
  localparam logic [1:0] PROG_HEAVY  = 2'd2;

  // Fault codes
  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_FILL  = 2'b01;
  localparam logic [1:0] FLT_DRAIN = 2'b10;

endpackage
`default_nettype wire

// File: rtl/wash_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : wash_tick_prescaler
// Purpose : Divides clk by TICK_DIV into a one-clock tick; restart_i holds
//           the divider at 0 so the first tick lands TICK_DIV clks after
//           restart_i is released.
// Revision: 1.0 - initial release
// ============================================================================
module wash_tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam int             PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q;

  // Free-running divider, wraps at TICK_DIV-1, held at 0 during restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else if (restart_i || (pre_q == LAST)) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  assign tick_o = (pre_q == LAST);

endmodule
`default_nettype wire

// File: rtl/wash_phase_timer.sv
`default_nettype none
// ============================================================================
// Module  : wash_phase_timer
// Purpose : Times the wash and spin phases for the washer FSM and watchdogs
//           the fill and drain phases, raising a latched fault on overrun.
// Revision: 1.0 - initial release
// ============================================================================
module wash_phase_timer
  import wash_pkg::*;
#(
  parameter int TICK_DIV    = 1000,
  parameter int CNT_W       = 16,
  parameter int QUICK_WASH  = 300,
  parameter int NORMAL_WASH = 600,
  parameter int HEAVY_WASH  = 900,
  parameter int SPIN_T      = 200,
  parameter int FILL_LIMIT  = 400,
  parameter int DRAIN_LIMIT = 400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       prog_sel,
  input  logic             prog_load,
  input  logic             run_cycle,
  input  logic             run_spin,
  input  logic             fill_active,
  input  logic             drain_active,
  input  logic             rinse,
  input  logic             fault_clr,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [1:0]       prog_active,
  output logic [CNT_W-1:0] remaining
);

  localparam int TW = CNT_W + 1;

  // Clamp a wide target into CNT_W bits; a zero target still waits one tick
  function automatic logic [CNT_W-1:0] sat_target(input logic [TW-1:0] raw);
    if (raw == '0)  return CNT_W'(1);
    if (raw[CNT_W]) return '1;
    return raw[CNT_W-1:0];
  endfunction

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] target_d;
  logic [1:0]       prog_d;
  logic             spin_q;
  logic             cycle_to_q;
  logic             spin_to_q;
  logic             fault_q;
  logic [1:0]       fault_code_q;
  logic [1:0]       prog_q;
  logic             counting;
  logic             tick;
  logic             last_tick;

  assign counting = (state_q == ST_COUNT_CYCLE) || (state_q == ST_COUNT_SPIN) ||
                    (state_q == ST_WATCH_FILL)  || (state_q == ST_WATCH_DRAIN);

  // The tick that brings the count up to the target ends the phase
  assign last_tick = tick && ((count_q + CNT_W'(1)) >= target_q);

  wash_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .restart_i (!counting),
    .tick_o    (tick)
  );

  // Target for the phase about to be entered from IDLE; a same-edge program
  // load already applies to it
  always_comb begin
    logic [TW-1:0] wash_raw;
    logic [TW-1:0] spin_raw;
    prog_d = prog_load ? prog_sel : prog_q;
    case (prog_d)
      PROG_QUICK: wash_raw = TW'(QUICK_WASH);
      PROG_HEAVY: wash_raw = TW'(HEAVY_WASH);
      default:    wash_raw = TW'(NORMAL_WASH);
    endcase
    if (rinse) wash_raw = wash_raw >> 1;
    spin_raw = (prog_d == PROG_HEAVY) ? TW'(2 * SPIN_T) : TW'(SPIN_T);
    if (fill_active)       target_d = sat_target(TW'(FILL_LIMIT));
    else if (drain_active) target_d = sat_target(TW'(DRAIN_LIMIT));
    else if (run_cycle)    target_d = sat_target(wash_raw);
    else                   target_d = sat_target(spin_raw);
  end

  // Phase state machine with registered timeout/fault outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      target_q     <= '0;
      spin_q       <= 1'b0;
      cycle_to_q   <= 1'b0;
      spin_to_q    <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FLT_NONE;
      prog_q       <= PROG_NORMAL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          count_q <= '0;
          if (prog_load) prog_q <= prog_sel;
          if (fill_active || drain_active || run_cycle || run_spin) target_q <= target_d;
          if (fill_active)       state_q <= ST_WATCH_FILL;
          else if (drain_active) state_q <= ST_WATCH_DRAIN;
          else if (run_cycle)    state_q <= ST_COUNT_CYCLE;
          else if (run_spin)     state_q <= ST_COUNT_SPIN;
        end
        ST_COUNT_CYCLE, ST_COUNT_SPIN: begin
          if ((state_q == ST_COUNT_CYCLE) ? !run_cycle : !run_spin) begin
            state_q <= ST_IDLE;
            count_q <= '0;
          end else if (last_tick) begin
            state_q    <= ST_EXPIRED;
            count_q    <= '0;
            spin_q     <= (state_q == ST_COUNT_SPIN);
            cycle_to_q <= (state_q == ST_COUNT_CYCLE);
            spin_to_q  <= (state_q == ST_COUNT_SPIN);
          end else if (tick) begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        ST_WATCH_FILL, ST_WATCH_DRAIN: begin
          if ((state_q == ST_WATCH_FILL) ? !fill_active : !drain_active) begin
            state_q <= ST_IDLE;
            count_q <= '0;
          end else if (last_tick) begin
            state_q      <= ST_FAULT;
            count_q      <= '0;
            fault_q      <= 1'b1;
            fault_code_q <= (state_q == ST_WATCH_FILL) ? FLT_FILL : FLT_DRAIN;
          end else if (tick) begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        ST_EXPIRED: begin
          if (spin_q ? !run_spin : !run_cycle) begin
            state_q    <= ST_IDLE;
            cycle_to_q <= 1'b0;
            spin_to_q  <= 1'b0;
          end
        end
        ST_FAULT: begin
          if (fault_clr && !run_cycle && !run_spin && !fill_active && !drain_active) begin
            state_q      <= ST_IDLE;
            fault_q      <= 1'b0;
            fault_code_q <= FLT_NONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cycle_timeout = cycle_to_q;
  assign spin_timeout  = spin_to_q;
  assign fault         = fault_q;
  assign fault_code    = fault_code_q;
  assign prog_active   = prog_q;
  assign remaining     = counting ? (target_q - count_q) : '0;

endmodule
`default_nettype wire

// File: tb/tb_wash_phase_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_wash_phase_timer
// Purpose : Directed self-checking bench for wash_phase_timer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wash_phase_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] prog_sel;
  logic       prog_load, run_cycle, run_spin, fill_active, drain_active, rinse, fault_clr;
  logic       cycle_timeout, spin_timeout, fault;
  logic [1:0] fault_code, prog_active;
  logic [7:0] remaining;

  int n_assert = 0;
  int n_fail   = 0;

  wash_phase_timer #(
    .TICK_DIV(2), .CNT_W(8), .QUICK_WASH(3), .NORMAL_WASH(5), .HEAVY_WASH(8),
    .SPIN_T(4), .FILL_LIMIT(6), .DRAIN_LIMIT(6)
  ) dut (
    .clk(clk), .reset(reset), .prog_sel(prog_sel), .prog_load(prog_load),
    .run_cycle(run_cycle), .run_spin(run_spin), .fill_active(fill_active),
    .drain_active(drain_active), .rinse(rinse), .fault_clr(fault_clr),
    .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout), .fault(fault),
    .fault_code(fault_code), .prog_active(prog_active), .remaining(remaining)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; prog_sel = 2'd0; prog_load = 1'b0; run_cycle = 1'b0; run_spin = 1'b0;
    fill_active = 1'b0; drain_active = 1'b0; rinse = 1'b0; fault_clr = 1'b0;
    cyc(2);
    chk("rst_cto",  32'(cycle_timeout), 32'd0);
    chk("rst_sto",  32'(spin_timeout),  32'd0);
    chk("rst_flt",  32'(fault),         32'd0);
    chk("rst_code", 32'(fault_code),    32'd0);
    chk("rst_prog", 32'(prog_active),   32'd1);
    chk("rst_rem",  32'(remaining),     32'd0);
    reset = 1'b0;
    cyc(1);

    // Normal wash, 5 ticks * 2 clks: timeout at the 11th edge
    run_cycle = 1'b1;
    cyc(1);
    chk("wash_rem_start", 32'(remaining), 32'd5);
    chk("wash_cto_start", 32'(cycle_timeout), 32'd0);
    cyc(8);
    chk("wash_rem_last", 32'(remaining), 32'd1);
    cyc(1);
    chk("wash_cto_clk10", 32'(cycle_timeout), 32'd0);
    cyc(1);
    chk("wash_cto_clk11", 32'(cycle_timeout), 32'd1);
    chk("wash_rem_exp",   32'(remaining), 32'd0);
    cyc(3);
    chk("wash_cto_hold", 32'(cycle_timeout), 32'd1);
    run_cycle = 1'b0;
    cyc(1);
    chk("wash_cto_drop", 32'(cycle_timeout), 32'd0);

    // Load heavy, then spin 2*4 ticks: timeout at edge 17
    prog_sel = 2'd2; prog_load = 1'b1;
    cyc(1);
    prog_load = 1'b0;
    chk("load_heavy", 32'(prog_active), 32'd2);
    run_spin = 1'b1;
    cyc(16);
    chk("spin_sto_clk16", 32'(spin_timeout), 32'd0);
    cyc(1);
    chk("spin_sto_clk17", 32'(spin_timeout), 32'd1);
    chk("spin_cto_clk17", 32'(cycle_timeout), 32'd0);
    run_spin = 1'b0;
    cyc(1);
    chk("spin_sto_drop", 32'(spin_timeout), 32'd0);

    // Heavy rinse wash, 8>>1 = 4 ticks: timeout at edge 9
    rinse = 1'b1; run_cycle = 1'b1;
    cyc(1);
    chk("rinse_rem", 32'(remaining), 32'd4);
    cyc(7);
    chk("rinse_cto_clk8", 32'(cycle_timeout), 32'd0);
    cyc(1);
    chk("rinse_cto_clk9", 32'(cycle_timeout), 32'd1);
    run_cycle = 1'b0; rinse = 1'b0;
    cyc(1);
    chk("rinse_cto_drop", 32'(cycle_timeout), 32'd0);

    // Fill overrun: 6 ticks -> fault at edge 13
    fill_active = 1'b1;
    cyc(12);
    chk("fill_flt_clk12", 32'(fault), 32'd0);
    cyc(1);
    chk("fill_flt_clk13", 32'(fault), 32'd1);
    chk("fill_code",      32'(fault_code), 32'd1);
    chk("fill_rem",       32'(remaining), 32'd0);
    fault_clr = 1'b1;
    cyc(2);
    chk("fill_clr_blocked", 32'(fault), 32'd1);
    fault_clr = 1'b0;
    cyc(5);
    fill_active = 1'b0;
    cyc(1);
    chk("fill_no_clr", 32'(fault), 32'd1);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    chk("fill_clr_flt",  32'(fault), 32'd0);
    chk("fill_clr_code", 32'(fault_code), 32'd0);

    // Drain for 10 clks then released: no fault
    drain_active = 1'b1;
    cyc(1);
    chk("drain_rem_start", 32'(remaining), 32'd6);
    cyc(9);
    chk("drain_rem_clk10", 32'(remaining), 32'd2);
    drain_active = 1'b0;
    cyc(1);
    chk("drain_rel_rem", 32'(remaining), 32'd0);
    chk("drain_rel_flt", 32'(fault), 32'd0);

    // Drain overrun: fault code 10 at edge 13
    drain_active = 1'b1;
    cyc(12);
    chk("drain_flt_clk12", 32'(fault), 32'd0);
    cyc(1);
    chk("drain_flt_clk13", 32'(fault), 32'd1);
    chk("drain_code",      32'(fault_code), 32'd2);
    drain_active = 1'b0; fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    chk("drain_clr", 32'(fault), 32'd0);

    // Program load during COUNT_CYCLE is ignored; heavy = 8 ticks
    run_cycle = 1'b1;
    cyc(2);
    prog_sel = 2'd0; prog_load = 1'b1;
    cyc(1);
    prog_load = 1'b0;
    chk("load_ignored", 32'(prog_active), 32'd2);
    chk("heavy_rem_clk3", 32'(remaining), 32'd7);
    cyc(13);
    chk("heavy_rem_clk16", 32'(remaining), 32'd1);
    // Drop on the expiry edge: no timeout at all
    run_cycle = 1'b0;
    cyc(1);
    chk("drop_exp_cto", 32'(cycle_timeout), 32'd0);
    chk("drop_exp_rem", 32'(remaining), 32'd0);
    cyc(2);
    chk("drop_exp_cto_later", 32'(cycle_timeout), 32'd0);

    // Load with level rise on the same edge: quick (3 ticks) applies
    prog_sel = 2'd0; prog_load = 1'b1; run_cycle = 1'b1;
    cyc(1);
    prog_load = 1'b0;
    chk("load_rise_prog", 32'(prog_active), 32'd0);
    chk("load_rise_rem",  32'(remaining), 32'd3);
    cyc(6);
    chk("quick_cto_clk7", 32'(cycle_timeout), 32'd1);

    // Asynchronous reset while the timeout is high
    reset = 1'b1;
    #2;
    chk("async_cto",  32'(cycle_timeout), 32'd0);
    chk("async_prog", 32'(prog_active), 32'd1);
    chk("async_rem",  32'(remaining), 32'd0);
    run_cycle = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(2);
    chk("post_rst_cto", 32'(cycle_timeout), 32'd0);
    chk("post_rst_flt", 32'(fault), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
